// File: rtl/mem_arbiter_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package mem_arbiter_pkg;

  localparam int unsigned DEF_SIZE_CNT = 3;
  localparam int unsigned DEF_CNT_CLK  = 2;
  localparam int unsigned ADDR_W       = 4;
  localparam int unsigned DATA_W       = 8;

  // Transaction phase: grant decision, memory fire, completion
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } port_t;

  // Command captured from the winning requester
  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
  } mem_cmd_t;

endpackage

// File: rtl/mem_arbiter_rr_arb2.sv
// Two-input round-robin arbiter; a tie goes to the port not granted last.
module rr_arb2
  import mem_arbiter_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  input  logic  req_a,
  input  logic  req_b,
  input  logic  take,
  output logic  valid_c,
  output port_t port_c
);

  port_t last;

  assign valid_c = req_a | req_b;

  // Winner selection from the current requests and last grant
  always_comb begin
    port_c = PORT_A;
    if (req_a && req_b) begin
      if (last == PORT_A) begin
        port_c = PORT_B;
      end
    end else if (req_b) begin
      port_c = PORT_B;
    end
  end

  // Last-grant register, starts at B so A wins the first tie
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= PORT_B;
    end else if (take) begin
      last <= port_c;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates CPU (A) and loader (B) ports onto one memory with a fixed
// three-cycle IDLE/ISSUE/RESP transaction.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned SIZE_CNT = DEF_SIZE_CNT,
  parameter int unsigned CNT_CLK  = DEF_CNT_CLK
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_wr,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_done,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_wr,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_done,
  output logic [DATA_W-1:0] b_rdata,
  output logic [SIZE_CNT:0] mem_cnt,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_dout
);

  localparam int unsigned      CNT_W    = SIZE_CNT + 1;
  localparam logic [SIZE_CNT:0] FIRE_CNT = CNT_W'(CNT_CLK + 1);

  // The fire phase must be representable on mem_cnt
  if ((CNT_CLK + 1) > ((1 << CNT_W) - 1)) begin : g_cnt_check
    $error("mem_arbiter: CNT_CLK+1 does not fit in mem_cnt");
  end

  state_t   state;
  port_t    sel;
  logic     cur_wr;
  logic     take_c;
  logic     arb_valid_c;
  port_t    arb_port_c;
  mem_cmd_t a_cmd_c;
  mem_cmd_t b_cmd_c;
  mem_cmd_t win_cmd_c;

  assign take_c    = (state == ST_IDLE) && arb_valid_c;
  assign a_cmd_c   = '{wr: a_wr, addr: a_addr, wdata: a_wdata};
  assign b_cmd_c   = '{wr: b_wr, addr: b_addr, wdata: b_wdata};
  assign win_cmd_c = (arb_port_c == PORT_B) ? b_cmd_c : a_cmd_c;

  rr_arb2 u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_a   (a_req),
    .req_b   (b_req),
    .take    (take_c),
    .valid_c (arb_valid_c),
    .port_c  (arb_port_c)
  );

  // Transaction FSM with all port and memory outputs registered
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      sel       <= PORT_A;
      cur_wr    <= 1'b0;
      a_gnt     <= 1'b0;
      a_done    <= 1'b0;
      a_rdata   <= '0;
      b_gnt     <= 1'b0;
      b_done    <= 1'b0;
      b_rdata   <= '0;
      mem_cnt   <= '0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (arb_valid_c) begin
            state     <= ST_ISSUE;
            sel       <= arb_port_c;
            cur_wr    <= win_cmd_c.wr;
            a_gnt     <= (arb_port_c == PORT_A);
            b_gnt     <= (arb_port_c == PORT_B);
            mem_cnt   <= FIRE_CNT;
            mem_wr    <= win_cmd_c.wr;
            mem_addr  <= win_cmd_c.addr;
            mem_wdata <= win_cmd_c.wdata;
          end
        end
        ST_ISSUE: begin
          state     <= ST_RESP;
          a_done    <= (sel == PORT_A);
          b_done    <= (sel == PORT_B);
          mem_cnt   <= '0;
          mem_wr    <= 1'b0;
          mem_addr  <= '0;
          mem_wdata <= '0;
        end
        ST_RESP: begin
          state  <= ST_IDLE;
          a_gnt  <= 1'b0;
          b_gnt  <= 1'b0;
          a_done <= 1'b0;
          b_done <= 1'b0;
          if (!cur_wr) begin
            if (sel == PORT_A) begin
              a_rdata <= mem_dout;
            end else begin
              b_rdata <= mem_dout;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
